// File: rtl/frame_buffer_1bpc_if.sv
// Pixel-source write port of the double-buffered HUB75 frame store.
interface frame_buffer_1bpc_if #(
    parameter int unsigned COLS  = 64,
    parameter int unsigned LINES = 32
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned LW = $clog2(LINES);

    logic          wr_valid;
    logic          wr_ready;
    logic [CW-1:0] wr_x;
    logic [LW:0]   wr_y;
    logic [2:0]    wr_rgb;

    modport master (output wr_valid, output wr_x, output wr_y, output wr_rgb, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_x, input  wr_y, input  wr_rgb, output wr_ready);
endinterface

// File: rtl/frame_buffer_1bpc.sv
// Double-buffered 1-bit-per-channel RGB frame store for a 64x64 HUB75 panel.
// Optional feature: FB_CLEAR_ON_SWAP_EN zero-fills the new back buffer after every swap and reset.
module frame_buffer_1bpc #(
    parameter int unsigned COLS  = 64,
    parameter int unsigned LINES = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    frame_buffer_1bpc_if.slave       wr,
    input  logic                     swap_req,
    output logic                     swap_done,
    input  logic                     frame_end,
    input  logic                     rd_en,
    input  logic [$clog2(LINES)-1:0] rd_line,
    input  logic [$clog2(COLS)-1:0]  rd_column,
    output logic                     r1,
    output logic                     g1,
    output logic                     b1,
    output logic                     r2,
    output logic                     g2,
    output logic                     b2
);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned LW    = $clog2(LINES);
    localparam int unsigned AW    = 1 + LW + CW;
    localparam int unsigned DEPTH = 2 * LINES * COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

`ifdef FB_CLEAR_ON_SWAP_EN
    localparam state_t RST_STATE = ST_CLEAR;
    localparam logic   RST_READY = 1'b0;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_READY = 1'b1;
`endif

    state_t        state;
    logic          front;
    logic          wr_ready_q;
    logic          wr_fire;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // Upper-half and lower-half banks, each holding both buffers.
    logic [2:0] mem_up [DEPTH];
    logic [2:0] mem_lo [DEPTH];

`ifdef FB_CLEAR_ON_SWAP_EN
    logic [LW+CW-1:0] clr_cnt;
`endif

    assign wr.wr_ready = wr_ready_q;
    assign wr_fire     = wr.wr_valid & wr_ready_q;
    assign waddr       = {~front, wr.wr_y[LW-1:0], wr.wr_x};
    assign raddr       = {front, rd_line, rd_column};

    // Swap control: a request arms the swap, the scan driver's frame end commits it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            front      <= 1'b0;
            wr_ready_q <= RST_READY;
            swap_done  <= 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
            clr_cnt    <= '0;
`endif
        end else begin
            swap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (swap_req) begin
                        state      <= ST_PEND;
                        wr_ready_q <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (frame_end) begin
                        front     <= ~front;
                        swap_done <= 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
                        state     <= ST_CLEAR;
                        clr_cnt   <= '0;
`else
                        state      <= ST_IDLE;
                        wr_ready_q <= 1'b1;
`endif
                    end
                end
`ifdef FB_CLEAR_ON_SWAP_EN
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state      <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Write port: always targets the back buffer; contents are intentionally not reset.
    always_ff @(posedge clk) begin
`ifdef FB_CLEAR_ON_SWAP_EN
        if (state == ST_CLEAR) begin
            mem_up[{~front, clr_cnt}] <= 3'b000;
            mem_lo[{~front, clr_cnt}] <= 3'b000;
        end else
`endif
        if (wr_fire) begin
            if (wr.wr_y[LW]) begin
                mem_lo[waddr] <= wr.wr_rgb;
            end else begin
                mem_up[waddr] <= wr.wr_rgb;
            end
        end
    end

    // Read port: one-cycle latency from the front buffer, holding when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r1, g1, b1} <= 3'b000;
            {r2, g2, b2} <= 3'b000;
        end else if (rd_en) begin
            {r1, g1, b1} <= mem_up[raddr];
            {r2, g2, b2} <= mem_lo[raddr];
        end
    end

endmodule

// File: tb/tb_frame_buffer_1bpc.sv
// Randomized self-checking bench for frame_buffer_1bpc against an array-based frame model.
module tb_frame_buffer_1bpc;
    logic       clk;
    logic       rst_n;
    logic       swap_req;
    logic       swap_done;
    logic       frame_end;
    logic       rd_en;
    logic [4:0] rd_line;
    logic [5:0] rd_column;
    logic       r1, g1, b1, r2, g2, b2;

    frame_buffer_1bpc_if #(.COLS(64), .LINES(32)) wif ();

    frame_buffer_1bpc #(.COLS(64), .LINES(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wif),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .frame_end (frame_end),
        .rd_en     (rd_en),
        .rd_line   (rd_line),
        .rd_column (rd_column),
        .r1        (r1),
        .g1        (g1),
        .b1        (b1),
        .r2        (r2),
        .g2        (g2),
        .b2        (b2)
    );

`ifdef FB_CLEAR_ON_SWAP_EN
    localparam bit CLEAR_EN  = 1'b1;
`else
    localparam bit CLEAR_EN  = 1'b0;
`endif
    localparam int CLEAR_LEN = 2048;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_pulse = 0;

    // Frame model: [bank][buffer][line*64+col], plus swap bookkeeping.
    bit [2:0] m_mem [2][2][2048];
    bit       m_front;
    bit       m_pend;
    int       m_busy;
    bit [5:0] m_out;
    bit       m_done;
    bit       m_ready;

    // Stimulus for the next clock edge.
    bit       d_v, d_sreq, d_fend, d_ren;
    int       d_x, d_y, d_line, d_col;
    bit [2:0] d_rgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear_back();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 2048; i++)
                m_mem[b][!m_front][i] = 3'b000;
    endtask

    task automatic model_reset();
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_out   = '0;
        m_done  = 1'b0;
        m_busy  = CLEAR_EN ? CLEAR_LEN : 0;
        if (CLEAR_EN) model_clear_back();
        m_ready = (m_busy == 0);
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = !m_pend && (m_busy == 0);
        if (d_ren)
            m_out = {m_mem[0][m_front][d_line*64 + d_col], m_mem[1][m_front][d_line*64 + d_col]};
        if (d_v && rdy)
            m_mem[d_y / 32][!m_front][(d_y % 32)*64 + d_x] = d_rgb;
        m_done = 1'b0;
        if (m_pend && d_fend) begin
            m_done  = 1'b1;
            m_front = !m_front;
            m_pend  = 1'b0;
            if (CLEAR_EN) begin
                m_busy = CLEAR_LEN;
                model_clear_back();
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (!m_pend && d_sreq) begin
            m_pend = 1'b1;
        end
        m_ready = !m_pend && (m_busy == 0);
    endtask

    // One clock: apply stimulus, advance model, compare all outputs, drop single-cycle strobes.
    task automatic tick();
        wif.wr_valid = d_v;
        wif.wr_x     = 6'(d_x);
        wif.wr_y     = 6'(d_y);
        wif.wr_rgb   = d_rgb;
        swap_req     = d_sreq;
        frame_end    = d_fend;
        rd_en        = d_ren;
        rd_line      = 5'(d_line);
        rd_column    = 6'(d_col);
        @(posedge clk);
        model_edge();
        #1;
        check("wr_ready", 32'(wif.wr_ready), 32'(m_ready));
        check("swap_done", 32'(swap_done), 32'(m_done));
        check("pixels", 32'({r1, g1, b1, r2, g2, b2}), 32'(m_out));
        if (swap_done === 1'b1) n_pulse++;
        d_v = 0; d_sreq = 0; d_fend = 0; d_ren = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!m_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic write_px(input int x, input int y, input bit [2:0] rgb);
        wait_ready();
        d_v = 1; d_x = x; d_y = y; d_rgb = rgb;
        tick();
    endtask

    task automatic do_swap();
        wait_ready();
        d_sreq = 1;
        tick();
        d_fend = 1;
        tick();
    endtask

    task automatic read_px(input int line, input int col);
        d_ren = 1; d_line = line; d_col = col;
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        d_v = 0; d_sreq = 0; d_fend = 0; d_ren = 0;
        d_x = 0; d_y = 0; d_line = 0; d_col = 0; d_rgb = 3'b000;
        wif.wr_valid = 0; wif.wr_x = 0; wif.wr_y = 0; wif.wr_rgb = 0;
        swap_req = 0; frame_end = 0; rd_en = 0; rd_line = 0; rd_column = 0;
        model_reset();
        #12;
        check("reset_ready", 32'(wif.wr_ready), 32'(!CLEAR_EN));
        check("reset_done", 32'(swap_done), 32'd0);
        check("reset_pixels", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero both buffers so every model entry is known.
        for (int p = 0; p < 2; p++) begin
            for (int y = 0; y < 64; y++)
                for (int x = 0; x < 64; x++)
                    write_px(x, y, 3'b000);
            do_swap();
        end

        // Single upper-half pixel becomes visible after a swap.
        write_px(5, 3, 3'b101);
        d_sreq = 1; tick();
        d_fend = 1; tick();
        check("t1_swap_done", 32'(swap_done), 32'd1);
        read_px(3, 5);
        check("t1_pixel", 32'({r1, g1, b1, r2, g2, b2}), 32'b101000);

        // Lower-half pixel at the last column; last line checks the address wrap.
        write_px(63, 35, 3'b010);
        do_swap();
        read_px(3, 63);
        check("t2_lower", 32'({r1, g1, b1, r2, g2, b2}), 32'b000010);
        read_px(31, 63);
        check("t2_wrap", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
        read_px(4, 0);
        check("t2_next_line", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);

        // Request and frame end together: swap waits for the following frame end.
        wait_ready();
        d_sreq = 1; d_fend = 1; tick();
        check("t3_no_done", 32'(swap_done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_pend_ready", 32'(wif.wr_ready), 32'd0);
        end
        d_fend = 1; tick();
        check("t3_done", 32'(swap_done), 32'd1);

        // Repeated request while pending yields one swap only.
        write_px(10, 20, 3'b111);
        n_pulse = 0;
        d_sreq = 1; tick();
        tick(); tick(); tick();
        d_sreq = 1; tick();
        tick(); tick();
        d_fend = 1; tick();
`ifdef FB_CLEAR_ON_SWAP_EN
        n = 0;
        while (wif.wr_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("clear_cycles", 32'(n), 32'(CLEAR_LEN));
`endif
        for (int i = 0; i < 10; i++) tick();
        check("t4_one_pulse", 32'(n_pulse), 32'd1);
        read_px(20, 10);
        check("t4_front_once", 32'({r1, g1, b1, r2, g2, b2}), 32'b111000);

`ifdef FB_CLEAR_ON_SWAP_EN
        // The cleared old front becomes visible after the next swap.
        do_swap();
        for (int i = 0; i < 64; i++) begin
            read_px($urandom_range(0, 31), $urandom_range(0, 63));
            check("clear_readback", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
        end
`endif

        // Random traffic on all ports.
        for (int i = 0; i < 3000; i++) begin
            d_v    = ($urandom_range(0, 1) == 1);
            d_x    = $urandom_range(0, 63);
            d_y    = $urandom_range(0, 63);
            d_rgb  = 3'($urandom_range(0, 7));
            d_sreq = ($urandom_range(0, 49) == 0);
            d_fend = ($urandom_range(0, 29) == 0);
            d_ren  = ($urandom_range(0, 1) == 1);
            d_line = $urandom_range(0, 31);
            d_col  = $urandom_range(0, 63);
            tick();
        end

        // Reset during PEND aborts the swap immediately.
        wait_ready();
        d_sreq = 1; tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pend_ready", 32'(wif.wr_ready), 32'(!CLEAR_EN));
        check("rst_pend_done", 32'(swap_done), 32'd0);
        check("rst_pend_pixels", 32'({r1, g1, b1, r2, g2, b2}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        d_fend = 1; tick();
        check("rst_no_swap", 32'(swap_done), 32'd0);
        for (int i = 0; i < 20; i++)
            read_px($urandom_range(0, 31), $urandom_range(0, 63));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
